pipeline_memstage_ctrl: RTL and testbench

//  Consumer end of the EX/MEM pipeline latch. Takes the latched memory-stage controls (dmemREN_dl,

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/pipeline_memstage_ctrl.sv | 121 ++++++++++++
 tb/tb_pipeline_memstage_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, memory-stage controller states and
// the mask used to force data-cache addresses onto word boundaries.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } memstate_t;

  localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic word_t wordAlign(input word_t addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pipeline_memstage_ctrl.sv
// Memory-stage controller at the consumer end of the EX/MEM latch: issues one
// data-cache request per latched instruction, stalls the pipe until dhit, and sequences halt.
module pipeline_memstage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  dmemREN_dl,
  input  logic  dmemWEN_dl,
  input  word_t porto_l,
  input  word_t portb_dl,
  input  logic  halt_dl,
  input  logic  pipe_en,
  input  logic  flush,
  input  logic  dhit,
  input  word_t dmemload,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output logic  mem_stall,
  output word_t memload_l,
  output logic  halt,
  output logic  err_timeout
);

  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  memstate_t  r_state;
  logic [7:0] r_timer;
  logic       r_ren;
  logic       r_wen;
  word_t      r_addr;
  word_t      r_store;
  word_t      r_memload;
  logic       r_halt;
  logic       r_err;

  logic       w_memReq;
  logic       w_issue;
  logic       w_enterHalt;
  logic [7:0] w_timerNext;

  // Issue and halt decisions are only made in IDLE, so DONE can never re-issue
  // the instruction still sitting in the latch while the pipe is held.
  always_comb begin
    w_memReq    = dmemREN_dl | dmemWEN_dl;
    w_issue     = (r_state == IDLE) & w_memReq & ~flush;
    w_enterHalt = (r_state == IDLE) & halt_dl & ~w_memReq & ~flush;
    w_timerNext = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;
    mem_stall   = w_issue | (r_state == ACCESS) | (r_state == HALTED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_store   <= '0;
      r_memload <= '0;
      r_halt    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state <= ACCESS;
            r_ren   <= dmemREN_dl;
            r_wen   <= dmemWEN_dl & ~dmemREN_dl;
            r_addr  <= wordAlign(porto_l);
            r_store <= portb_dl;
            r_timer <= '0;
          end else if (w_enterHalt) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
          end
        end
        // Flush is deliberately not looked at here: a started access always completes.
        ACCESS: begin
          if (dhit) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_state <= DONE;
            if (r_ren) begin
              r_memload <= dmemload;
            end
          end else begin
            r_timer <= w_timerNext;
            if (w_timerNext >= TIMEOUT_L) begin
              r_err <= 1'b1;
            end
          end
        end
        DONE: begin
          if (pipe_en) begin
            r_state <= IDLE;
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dmemREN     = r_ren;
  assign dmemWEN     = r_wen;
  assign dmemaddr    = r_addr;
  assign dmemstore   = r_store;
  assign memload_l   = r_memload;
  assign halt        = r_halt;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_pipeline_memstage_ctrl.sv
// Randomized scoreboard bench for pipeline_memstage_ctrl: a driver plays the
// pipeline, a monitor plays the data cache and checks each access it sees.
module tb_pipeline_memstage_ctrl;

  localparam int TMO       = 8;
  localparam int NUM_INSTR = 200;

  typedef struct {
    logic        isRead;
    logic [31:0] addr;
    logic [31:0] data;
    logic        slow;
  } expTxn_t;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        dmemREN_dl, dmemWEN_dl, halt_dl, pipe_en, flush, dhit;
  logic [31:0] porto_l, portb_dl, dmemload;
  logic        dmemREN, dmemWEN, mem_stall, halt, err_timeout;
  logic [31:0] dmemaddr, dmemstore, memload_l;

  int          vectors     = 0;
  int          miscompares = 0;
  int          doneCount   = 0;
  bit          monitorOn   = 1'b0;
  bit          forceHit    = 1'b0;
  logic [31:0] forceData   = '0;
  expTxn_t     expQ[$];

  pipeline_memstage_ctrl #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .dmemREN_dl(dmemREN_dl), .dmemWEN_dl(dmemWEN_dl), .porto_l(porto_l),
    .portb_dl(portb_dl), .halt_dl(halt_dl), .pipe_en(pipe_en), .flush(flush),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .memload_l(memload_l), .halt(halt), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic noteFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Present one latched instruction; kind 0-2 load, 3-5 store, 6 load+store,
  // 7 flushed load, 8-9 no memory op. Unflushed memory ops go to the scoreboard.
  task automatic applyStimulus(input int kind, input bit slow);
    expTxn_t t;
    dmemREN_dl = (kind <= 2) || (kind == 6) || (kind == 7);
    dmemWEN_dl = (kind >= 3) && (kind <= 6);
    porto_l    = $urandom;
    portb_dl   = $urandom;
    halt_dl    = 1'b0;
    flush      = (kind == 7);
    if (kind <= 6) begin
      t.isRead = dmemREN_dl;
      t.addr   = porto_l - (porto_l % 4);
      t.data   = portb_dl;
      t.slow   = slow;
      expQ.push_back(t);
    end
  endtask

  // Cache model and checker: compares each new request against the scoreboard,
  // answers with dhit, and tracks the expected load data and timeout flag.
  initial begin : monitor
    expTxn_t     cur;
    bit          inAccess;
    bit          errExp;
    int          noHit;
    logic [31:0] expLoad;
    inAccess = 1'b0;
    errExp   = 1'b0;
    noHit    = 0;
    expLoad  = '0;
    dhit     = 1'b0;
    dmemload = '0;
    forever begin
      @(negedge CLK);
      if (!monitorOn) begin
        dhit     = forceHit;
        dmemload = forceData;
        continue;
      end
      checkOutput("err_timeout", {31'd0, err_timeout}, {31'd0, errExp});
      checkOutput("memload_l", memload_l, expLoad);
      if (dmemREN || dmemWEN) begin
        if (!inAccess) begin
          if (expQ.size() == 0) begin
            noteFail("spurious request");
            dhit = 1'b1;
            continue;
          end
          cur      = expQ[0];
          inAccess = 1'b1;
          noHit    = 0;
          checkOutput("dmemREN", {31'd0, dmemREN}, {31'd0, cur.isRead});
          checkOutput("dmemWEN", {31'd0, dmemWEN}, {31'd0, !cur.isRead});
          checkOutput("dmemaddr", dmemaddr, cur.addr);
          if (!cur.isRead) checkOutput("dmemstore", dmemstore, cur.data);
        end
        dmemload = $urandom;
        if (cur.slow) dhit = (noHit >= TMO + 2);
        else          dhit = ($urandom_range(0, 1) == 1);
        if (dhit) begin
          void'(expQ.pop_front());
          if (cur.isRead) expLoad = dmemload;
          inAccess = 1'b0;
          doneCount++;
        end else begin
          noHit++;
          if (noHit >= TMO) errExp = 1'b1;
        end
      end else begin
        if (inAccess) begin
          noteFail("request dropped before dhit");
          inAccess = 1'b0;
          void'(expQ.pop_front());
        end
        dhit     = ($urandom_range(0, 3) == 0);
        dmemload = $urandom;
      end
    end
  end

  // Pipeline model: holds each instruction until the stage may advance and
  // checks mem_stall every cycle from the instruction's own history.
  initial begin : driver
    bit isOp, opDone, advanced, flushed, expStall;
    int kind, doneAcked, doneWait;
    nRST = 1'b0;
    dmemREN_dl = 0; dmemWEN_dl = 0; halt_dl = 0; pipe_en = 0; flush = 0;
    porto_l = '0; portb_dl = '0;
    doneAcked = 0;
    repeat (2) @(negedge CLK);
    #2;
    checkOutput("reset dmemREN", {31'd0, dmemREN}, 0);
    checkOutput("reset dmemWEN", {31'd0, dmemWEN}, 0);
    checkOutput("reset dmemaddr", dmemaddr, 0);
    checkOutput("reset dmemstore", dmemstore, 0);
    checkOutput("reset memload_l", memload_l, 0);
    checkOutput("reset halt", {31'd0, halt}, 0);
    checkOutput("reset err_timeout", {31'd0, err_timeout}, 0);
    checkOutput("reset mem_stall", {31'd0, mem_stall}, 0);
    nRST      = 1'b1;
    monitorOn = 1'b1;

    for (int n = 0; n < NUM_INSTR; n++) begin
      @(negedge CLK);
      #2;
      kind = $urandom_range(0, 9);
      if (n == 5) kind = 0;
      if (n == NUM_INSTR - 1) kind = 3;
      applyStimulus(kind, (n == 5) || ($urandom_range(0, 15) == 0));
      flushed  = (kind == 7);
      isOp     = (kind <= 6);
      opDone   = 1'b0;
      advanced = 1'b0;
      doneWait = 0;
      for (int c = 0; !advanced; c++) begin
        if (c > 0) begin
          @(negedge CLK);
          #2;
          flush = isOp && !opDone && ($urandom_range(0, 2) == 0);
        end
        if (doneCount != doneAcked) begin
          doneAcked = doneCount;
          opDone    = 1'b1;
          expStall  = 1'b1;
        end else begin
          expStall = isOp && !opDone;
        end
        #1;
        checkOutput("mem_stall", {31'd0, mem_stall}, {31'd0, expStall});
        checkOutput("halt", {31'd0, halt}, 0);
        if (flushed) pipe_en = 1'b1;
        else         pipe_en = ($urandom_range(0, 2) != 0);
        if (n == NUM_INSTR - 1 && !expStall && doneWait < 5) begin
          pipe_en = 1'b0;
          doneWait++;
        end
        advanced = pipe_en && !expStall;
        if (c > 300) begin
          noteFail("instruction never retired");
          advanced = 1'b1;
        end
      end
    end

    @(negedge CLK);
    #2;
    dmemREN_dl = 0; dmemWEN_dl = 0; halt_dl = 1; flush = 1; pipe_en = 1;
    #1 checkOutput("flushed halt stall", {31'd0, mem_stall}, 0);
    @(negedge CLK);
    #2;
    flush = 0;
    #1 checkOutput("halt before HALTED", {31'd0, halt}, 0);
    checkOutput("scoreboard drained", expQ.size(), 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      #2;
      dmemREN_dl = 1'($urandom_range(0, 1));
      dmemWEN_dl = 1'($urandom_range(0, 1));
      halt_dl    = 1'($urandom_range(0, 1));
      flush      = 1'($urandom_range(0, 1));
      porto_l    = $urandom;
      #1;
      checkOutput("halt sticky", {31'd0, halt}, 1);
      checkOutput("HALTED stall", {31'd0, mem_stall}, 1);
      checkOutput("HALTED no read", {31'd0, dmemREN}, 0);
      checkOutput("HALTED no write", {31'd0, dmemWEN}, 0);
    end

    monitorOn = 1'b0;
    nRST = 1'b0;
    dmemREN_dl = 0; dmemWEN_dl = 0; halt_dl = 0; flush = 0; pipe_en = 0;
    @(negedge CLK);
    #2;
    nRST = 1'b1;
    dmemREN_dl = 1; porto_l = 32'h0000_0104;
    @(negedge CLK);
    #2;
    forceHit = 1'b1; forceData = 32'hDEAD_BEEF;
    #1;
    checkOutput("directed load dmemREN", {31'd0, dmemREN}, 1);
    checkOutput("directed load dmemaddr", dmemaddr, 32'h0000_0104);
    checkOutput("directed load stall", {31'd0, mem_stall}, 1);
    @(negedge CLK);
    #2;
    forceHit = 1'b0;
    @(negedge CLK);
    #2;
    #1;
    checkOutput("directed memload_l", memload_l, 32'hDEAD_BEEF);
    checkOutput("directed DONE dmemREN", {31'd0, dmemREN}, 0);
    checkOutput("directed DONE stall", {31'd0, mem_stall}, 0);
    pipe_en = 1'b1;
    @(negedge CLK);
    #2;
    pipe_en = 1'b0;
    porto_l = 32'h0000_0208;
    @(negedge CLK);
    #2;
    #1 checkOutput("pre-reset dmemREN", {31'd0, dmemREN}, 1);
    nRST = 1'b0;
    #1;
    checkOutput("async reset dmemREN", {31'd0, dmemREN}, 0);
    checkOutput("async reset memload_l", memload_l, 0);
    checkOutput("async reset dmemaddr", dmemaddr, 0);
    dmemREN_dl = 1'b0;
    #1 checkOutput("async reset state IDLE", {31'd0, mem_stall}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    noteFail("global time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
